// File: rtl/instr_stream_loader.sv
// Packs an 8-bit byte stream little-endian into 64-bit words and writes them to instruction memory from address 0.
// Optional macro INSTR_LOADER_CHECKSUM_EN adds o_checksum, a 16-bit sum of all accepted bytes.

module isl_lane #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       wr,
  input  logic       clr,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  q <= PAD_BYTE;
    else if (clr)  q <= PAD_BYTE;
    else if (wr)   q <= d;
  end
endmodule

module instr_stream_loader #(
  parameter int         ADDR_W    = 15,
  parameter int         MAX_WORDS = 32768,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte_data,
  input  logic              i_byte_last,
  output logic              o_byte_rdy,
  output logic              o_instr_mem_wr_vld,
  output logic [ADDR_W-1:0] o_instr_mem_wr_addr,
  output logic [63:0]       o_instr_mem_wr_data,
  input  logic              i_instr_mem_wr_rdy,
  output logic              o_instr_mem_wr_finish,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,output logic [15:0]      o_checksum
`endif
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t               state, state_nxt;
  logic [2:0]           idx;
  logic                 word_last;
  logic [ADDR_W:0]      count;
  logic                 overflow;
  logic [7:0][7:0]      lanes;

  logic byte_acc, full, start_ok, wr_hs, keep, ovf_hit;

  assign byte_acc = i_byte_vld & o_byte_rdy;
  assign full     = (count == MAX_CNT);
  assign start_ok = i_load_start & ((state == IDLE) | (state == DONE));
  assign wr_hs    = o_instr_mem_wr_vld & i_instr_mem_wr_rdy;
  assign keep     = byte_acc & (state == COLLECT) & ~full;
  assign ovf_hit  = byte_acc & (state == COLLECT) & full;

  assign o_byte_rdy            = (state == COLLECT) | (state == DRAIN);
  assign o_instr_mem_wr_vld    = (state == WRITE);
  assign o_instr_mem_wr_finish = (state == DONE);
  assign o_busy                = (state != IDLE) & (state != DONE);
  assign o_overflow            = overflow;
  assign o_word_count          = count;
  // Address tracks the word count; it never wraps because the full guard fires first.
  assign o_instr_mem_wr_addr   = count[ADDR_W-1:0];
  assign o_instr_mem_wr_data   = lanes;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    isl_lane #(.PAD_BYTE(PAD_BYTE)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .wr      (keep && (idx == 3'(g))),
      .clr     (wr_hs || start_ok),
      .d       (i_byte_data),
      .q       (lanes[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_load_start) state_nxt = COLLECT;
      COLLECT: if (byte_acc) begin
                 if (full)                              state_nxt = i_byte_last ? DONE : DRAIN;
                 else if ((idx == 3'd7) || i_byte_last) state_nxt = WRITE;
               end
      WRITE:   if (wr_hs) state_nxt = word_last ? DONE : COLLECT;
      DRAIN:   if (byte_acc && i_byte_last) state_nxt = DONE;
      DONE:    if (i_load_start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx       <= '0;
      word_last <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
    end else if (start_ok) begin
      idx       <= '0;
      word_last <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (keep) begin
        idx       <= idx + 3'd1;
        word_last <= i_byte_last;
      end
      if (ovf_hit) overflow <= 1'b1;
      if (wr_hs) begin
        idx   <= '0;
        count <= count + 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  assign o_checksum = csum;

  // Drained bytes count too; pad bytes never pass through byte_acc.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      csum <= '0;
    else if (start_ok) csum <= '0;
    else if (byte_acc) csum <= csum + {8'h00, i_byte_data};
  end
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// Scoreboard bench for instr_stream_loader: expected words queued at stimulus time, checked at each write handshake.

module tb_instr_stream_loader;
  localparam int         ADDR_W    = 15;
  localparam int         MAX_WORDS = 2;
  localparam logic [7:0] PAD       = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_load_start = 1'b0;
  logic              i_byte_vld = 1'b0;
  logic [7:0]        i_byte_data = 8'h00;
  logic              i_byte_last = 1'b0;
  logic              o_byte_rdy;
  logic              o_instr_mem_wr_vld;
  logic [ADDR_W-1:0] o_instr_mem_wr_addr;
  logic [63:0]       o_instr_mem_wr_data;
  logic              i_instr_mem_wr_rdy = 1'b1;
  logic              o_instr_mem_wr_finish;
  logic              o_busy;
  logic              o_overflow;
  logic [ADDR_W:0]   o_word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [15:0]       o_checksum;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [7:0] stim[$];

  instr_stream_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .PAD_BYTE(PAD)) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_load_start          (i_load_start),
    .i_byte_vld            (i_byte_vld),
    .i_byte_data           (i_byte_data),
    .i_byte_last           (i_byte_last),
    .o_byte_rdy            (o_byte_rdy),
    .o_instr_mem_wr_vld    (o_instr_mem_wr_vld),
    .o_instr_mem_wr_addr   (o_instr_mem_wr_addr),
    .o_instr_mem_wr_data   (o_instr_mem_wr_data),
    .i_instr_mem_wr_rdy    (i_instr_mem_wr_rdy),
    .o_instr_mem_wr_finish (o_instr_mem_wr_finish),
    .o_busy                (o_busy),
    .o_overflow            (o_overflow),
    .o_word_count          (o_word_count)
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,.o_checksum           (o_checksum)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Handshake happens on the next posedge; sample at negedge while it is stable.
  always @(negedge i_clk) begin
    if (i_rst_n && o_instr_mem_wr_vld && i_instr_mem_wr_rdy) begin
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected addr=%0h data=%h", o_instr_mem_wr_addr, o_instr_mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (o_instr_mem_wr_addr !== e.addr || o_instr_mem_wr_data !== e.data) begin
          miscompares++;
          $display("FAIL wr_word got addr=%0h data=%h want addr=%0h data=%h",
                   o_instr_mem_wr_addr, o_instr_mem_wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_expected(input int max_words);
    exp_t e;
    logic [63:0] w;
    int lane, nw;
    lane = 0; nw = 0; w = {8{PAD}};
    for (int i = 0; i < stim.size(); i++) begin
      w[8*lane +: 8] = stim[i];
      lane++;
      if (lane == 8 || i == stim.size() - 1) begin
        if (nw < max_words) begin
          e.addr = nw[ADDR_W-1:0];
          e.data = w;
          exp_q.push_back(e);
        end
        nw++; lane = 0; w = {8{PAD}};
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge i_clk); #1;
    i_load_start = 1'b1;
    @(posedge i_clk); #1;
    i_load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    i_byte_vld = 1'b1; i_byte_data = b; i_byte_last = last;
    @(negedge i_clk);
    while (!o_byte_rdy && n < 300) begin @(negedge i_clk); n++; end
    if (n >= 300) begin
      vectors++; miscompares++;
      $display("FAIL byte_rdy_timeout got rdy=%0b want 1", o_byte_rdy);
    end
    @(posedge i_clk); #1;
    i_byte_vld = 1'b0; i_byte_last = 1'b0;
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], i == stim.size() - 1);
  endtask

  task automatic wait_finish(input string name);
    int n;
    n = 0;
    while (o_instr_mem_wr_finish !== 1'b1 && n < 500) begin @(posedge i_clk); #1; n++; end
    vectors++;
    if (o_instr_mem_wr_finish !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_finish_timeout got %0b want 1", name, o_instr_mem_wr_finish);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_writes got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({o_byte_rdy, o_instr_mem_wr_vld, o_instr_mem_wr_finish, o_busy, o_overflow} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000",
               {o_byte_rdy, o_instr_mem_wr_vld, o_instr_mem_wr_finish, o_busy, o_overflow});
    end
    vectors++;
    if (o_word_count !== '0 || o_instr_mem_wr_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_count got cnt=%0d addr=%0d want 0", o_word_count, o_instr_mem_wr_addr);
    end
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    push_expected(MAX_WORDS);
    pulse_start();
    vectors++;
    if (o_busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %0b want 1", o_busy); end
    for (int i = 0; i < 16; i++) begin
      send_byte(stim[i], i == 15);
      if (i == 7) begin
        vectors++;
        if (o_instr_mem_wr_vld !== 1'b1 || o_byte_rdy !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_latency got vld=%0b rdy=%0b want vld=1 rdy=0", o_instr_mem_wr_vld, o_byte_rdy);
        end
      end
    end
    vectors++;
    if (o_instr_mem_wr_finish !== 1'b0) begin miscompares++; $display("FAIL basic_early_finish got 1 want 0"); end
    @(posedge i_clk); #1;
    vectors++;
    if (o_instr_mem_wr_finish !== 1'b1) begin
      miscompares++; $display("FAIL basic_finish_timing got %0b want 1", o_instr_mem_wr_finish);
    end
    wait_finish("basic");
    vectors++;
    if (o_word_count !== 16'(2) || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_count got cnt=%0d busy=%0b want cnt=2 busy=0", o_word_count, o_busy);
    end
  endtask

  task automatic test_partial();
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(8'hA0 + 8'(i));
    push_expected(MAX_WORDS);
    pulse_start();
    vectors++;
    if (o_instr_mem_wr_finish !== 1'b0 || o_word_count !== '0) begin
      miscompares++; $display("FAIL partial_restart got fin=%0b cnt=%0d want fin=0 cnt=0", o_instr_mem_wr_finish, o_word_count);
    end
    send_stim();
    wait_finish("partial");
    vectors++;
    if (o_word_count !== 16'(2)) begin miscompares++; $display("FAIL partial_count got %0d want 2", o_word_count); end
  endtask

  task automatic test_backpressure();
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(8'h10 + 8'(i));
    push_expected(MAX_WORDS);
    i_instr_mem_wr_rdy = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stim[i], 1'b0);
    i_byte_vld = 1'b1; i_byte_data = 8'hEE;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      vectors++;
      if (o_instr_mem_wr_vld !== 1'b1 || o_byte_rdy !== 1'b0) begin
        miscompares++; $display("FAIL stall_ctrl got vld=%0b rdy=%0b want vld=1 rdy=0", o_instr_mem_wr_vld, o_byte_rdy);
      end
      vectors++;
      if (o_instr_mem_wr_addr !== '0 || o_instr_mem_wr_data !== 64'h1716151413121110) begin
        miscompares++; $display("FAIL stall_word got addr=%0h data=%h want addr=0 data=1716151413121110",
                                o_instr_mem_wr_addr, o_instr_mem_wr_data);
      end
    end
    @(posedge i_clk); #1;
    i_instr_mem_wr_rdy = 1'b1;
    send_byte(stim[8], 1'b1);
    wait_finish("stall");
  endtask

  task automatic test_overflow();
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(8'h30 + 8'(i));
    push_expected(MAX_WORDS);
    pulse_start();
    send_stim();
    wait_finish("overflow");
    vectors++;
    if (o_overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_flag got %0b want 1", o_overflow); end
    vectors++;
    if (o_word_count !== 16'(2)) begin miscompares++; $display("FAIL overflow_count got %0d want 2", o_word_count); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    vectors++;
    if (o_overflow !== 1'b0) begin miscompares++; $display("FAIL restart_ovf_clear got %0b want 0", o_overflow); end
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_busy, o_byte_rdy, o_instr_mem_wr_finish, o_instr_mem_wr_vld} !== 4'b0) begin
      miscompares++; $display("FAIL midreset_flags got %b want 0000", {o_busy, o_byte_rdy, o_instr_mem_wr_finish, o_instr_mem_wr_vld});
    end
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'h50 + 8'(i));
    push_expected(MAX_WORDS);
    pulse_start();
    send_stim();
    wait_finish("midreset");
    vectors++;
    if (o_word_count !== 16'(1)) begin miscompares++; $display("FAIL midreset_count got %0d want 1", o_word_count); end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'hFF);
    stim.push_back(8'h01);
    push_expected(MAX_WORDS);
    pulse_start();
    send_stim();
    wait_finish("checksum");
    vectors++;
    if (o_checksum !== 16'h07F9) begin miscompares++; $display("FAIL checksum got %h want 07f9", o_checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_overflow();
    test_reset_mid();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
Upstream feeder for the WASM core's instruction-memory write port. Takes an 8-bit byte stream from the host or debug link and packs every 8 bytes little-endian into a 64-bit instruction word. Writes words at consecutive addresses starting at 0 over the core's valid/ready write port. Asserts write-finish after the last word, which releases the core from its load phase.

Parameters:
- ADDR_W, 15, width of the instruction-memory word address.
- MAX_WORDS, 32768, number of writable words; must be ≤ 2**ADDR_W.
- PAD_BYTE, 8'h00, fill value for unused byte lanes of a final partial word.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load_start  in  1  one-cycle pulse; begins a load session.
- i_byte_vld  in  1  byte-stream valid.
- i_byte_data  in  8  stream byte.
- i_byte_last  in  1  marks the final byte of the program; qualified by i_byte_vld.
- o_byte_rdy  out  1  stream ready.
- o_instr_mem_wr_vld  out  1  write-word valid.
- o_instr_mem_wr_addr  out  ADDR_W  word address; starts at 0, no offset.
- o_instr_mem_wr_data  out  64  packed word; byte k occupies bits [8k+7:8k].
- i_instr_mem_wr_rdy  in  1  core ready to accept a word.
- o_instr_mem_wr_finish  out  1  load complete; level signal.
- o_busy  out  1  high in every state except IDLE and DONE.
- o_overflow  out  1  sticky; set when the program exceeds MAX_WORDS.
- o_word_count  out  ADDR_W+1  number of words written this session.

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values: all outputs 0; state IDLE; byte lane index 0; data register filled with PAD_BYTE.
- States:
  - IDLE: o_byte_rdy=0. On i_load_start, clear address, count and overflow, then go to COLLECT.
  - COLLECT: o_byte_rdy=1. Each accepted byte (vld & rdy) goes into lane idx, and idx increments.
    - If idx reaches 7 or i_byte_last is set, the word is complete: next cycle is WRITE and o_byte_rdy drops.
    - Unused lanes of a partial word hold PAD_BYTE.
  - WRITE: o_instr_mem_wr_vld=1. Data and address are stable until the handshake (vld & i_instr_mem_wr_rdy).
    - On handshake: address and count increment, the data register is refilled with PAD_BYTE, and idx returns to 0.
    - If the word was last, go to DONE; otherwise return to COLLECT.
    - Latency: the first WRITE cycle immediately follows the cycle in which the 8th byte is accepted.
  - DRAIN: entered from COLLECT when a byte arrives while count == MAX_WORDS.
    - Sets o_overflow; o_byte_rdy=1; bytes are discarded.
    - The byte carrying i_byte_last moves to DONE.
  - DONE: o_instr_mem_wr_finish=1, held high. i_load_start restarts the session: finish clears and the state goes to COLLECT.
- i_load_start outside IDLE and DONE is ignored.
- i_byte_last on the first byte of a word gives a word of 1 data byte + 7 pad bytes.
- i_load_start followed directly by i_byte_last with no data is impossible: last is always carried by a byte.
- Address wrap is impossible: the MAX_WORDS guard fires first.
- Reset mid-session: immediate return to IDLE; partial words are lost; finish is not asserted.
- The core may hold i_instr_mem_wr_rdy low indefinitely; the loader back-pressures the byte stream with o_byte_rdy=0 and loses no data.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output o_checksum[15:0]: a modulo-2^16 sum of every accepted byte, including DRAIN bytes but excluding pad bytes.
  - The sum clears on i_load_start and is valid in DONE.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Start, then 16 bytes 0x00..0x0F with last on 0x0F, wr_rdy=1 → two writes: addr0 = 64'h0706050403020100, addr1 = 64'h0F0E0D0C0B0A0908. Finish high 1 cycle after the second handshake; o_word_count=2.
- 11 bytes 0xA0..0xAA, last on 0xAA, PAD_BYTE=0 → addr1 data = 64'h0000000000AAA9A8; finish=1.
- wr_rdy held low for 20 cycles during the first write → vld/addr/data stable, o_byte_rdy=0 throughout; data intact after rdy rises.
- MAX_WORDS=2 with 24 bytes → 2 writes, then o_overflow=1, remaining 8 bytes discarded, finish=1, count=2.
- Reset pulse after 5 bytes, then restart with 8 bytes → single write, addr 0, correct data, no stale lanes.
- Checksum build: bytes 0xFF×8 then 0x01 (last) → o_checksum=16'h07F9.
